serial_shifter: RTL and testbench
=================================

Name: serial_shifter

Overview:
- Multi-cycle shift/rotate unit in the ALU bit-shift path.
- Sits directly downstream of the 20-bit operand swap stage and takes one of the swapped words as its operand.
- Moves the operand one bit position per clock. This keeps area small compared with a barrel shifter.
- Uses valid/ready handshakes on both the input and output sides, so it can stall against the writeback side.

Parameters:
- WIDTH, 20, operand/result width; matches the swap stage word width.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op/shamt are valid.
- in_ready  output  1  block can accept a new operation.
- in_data  input  WIDTH  operand (e.g. a_swapped from the swap stage).
- in_shamt  input  SHAMT_W  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_data=0; internal count=0; op register=00.
- States:
  - IDLE: in_ready=1. Accept occurs when in_valid&&in_ready at a rising edge (the accept edge).
    - Latches in_data, in_op and the effective amount k.
    - If k==0, go to DONE; otherwise go to SHIFT with count=k.
  - SHIFT: each edge shifts one position and decrements count. The edge where count==1 moves the state to DONE.
  - DONE: out_valid=1 and out_data is stable.
    - On out_valid&&out_ready, go to IDLE.
    - No bypass: a new operation cannot be accepted in the same edge as the output handshake. in_ready is 0 outside IDLE.
- Effective amount k:
  - SLL/SRL/SRA: k=min(in_shamt, WIDTH). Amounts >= WIDTH saturate, giving 0 for SLL/SRL and all sign bits for SRA.
  - ROL: k = in_shamt mod WIDTH.
- Per-step operation:
  - SLL: data<<1, zero fill.
  - SRL: data>>1, zero fill.
  - SRA: data>>1, fill with data[WIDTH-1].
  - ROL: {data[WIDTH-2:0], data[WIDTH-1]}.
- Latency:
  - out_valid first visible in the cycle after edge k, counted from the accept edge as edge 0. So k=0 gives a result one cycle after accept, and k=19 gives 19 further edges.
  - Throughput is one operation per k+2 cycles minimum, including the return to IDLE.
- Backpressure: while in DONE with out_ready=0, out_data and out_valid hold indefinitely.
- in_data/in_shamt/in_op are ignored outside IDLE. Changing them mid-operation has no effect.
- Reset mid-SHIFT or mid-DONE aborts immediately to reset values. The partial result is discarded.
- out_data is only meaningful while out_valid=1. It holds the last result (or its partially shifted value during SHIFT) at other times; verification must not check it then.

Optional Feature:
- Macro SERIAL_SHIFTER_FLAGS_EN.
- Defined: adds two output ports.
  - out_carry (1 bit): the last bit shifted out. It is 0 when k==0. For ROL it equals the bit that wrapped.
  - out_zero (1 bit): high when out_data==0.
  - Both reset to 0 and are valid with out_valid, holding under backpressure.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then SLL: in_data=20'hAAAAA, shamt=1, op=00.
  - Expect out_data=20'h55554, out_valid one cycle after the accept+1 edge.
  - With flags enabled, expect carry=1.
- SRA sign fill: in_data=20'h80000, shamt=4, op=10.
  - Expect out_data=20'hF8000 after 4 shift edges.
  - Expect busy high throughout and in_ready low.
- ROL wrap and modulo: in_data=20'h80001, shamt=1, op=11 -> 20'h00003.
  - Then in_data=20'h00001, shamt=25 -> k=5, out_data=20'h00020.
- Saturation and zero amount:
  - SLL 20'hFFFFF by 31 -> 20'h00000 (zero flag=1).
  - SRL 20'h12345 by 0 -> 20'h12345 one cycle after accept (carry=0).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/out_valid stable and in_ready=0; in_valid pulses are ignored. After out_ready=1, one handshake occurs, then IDLE with in_ready=1.
- Async reset mid-SHIFT: SLL by 15, drop rst_n at shift edge 7 (between edges) -> outputs at reset values immediately. After release, a fresh op completes correctly.

Source files
------------

// File: rtl/serial_shifter_if.sv
// Handshake/bus bundle for serial_shifter: operand input side and result output side.
// out_carry/out_zero exist only when SERIAL_SHIFTER_FLAGS_EN is defined.
interface serial_shifter_if #(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               busy;
`ifdef SERIAL_SHIFTER_FLAGS_EN
    logic               out_carry;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy, out_carry, out_zero
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/serial_shifter.sv
// Serial shift/rotate unit: moves the operand one bit per clock, valid/ready on both sides.
// Define SERIAL_SHIFTER_FLAGS_EN to add the out_carry/out_zero result flags.
module serial_shifter #(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_shifter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] k_eff;
    logic             in_ready_q, out_valid_q, busy_q;

    function automatic logic [WIDTH-1:0] step1(input op_e op, input logic [WIDTH-1:0] d);
        case (op)
            OP_SLL:  step1 = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  step1 = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  step1 = {d[WIDTH-1], d[WIDTH-1:1]};
            default: step1 = {d[WIDTH-2:0], d[WIDTH-1]};
        endcase
    endfunction

    // Linear shifts saturate at WIDTH steps; rotates wrap modulo WIDTH.
    always_comb begin
        if (op_e'(bus.in_op) == OP_ROL) begin
            k_eff = CNT_W'(32'(bus.in_shamt) % WIDTH);
        end else if (32'(bus.in_shamt) >= WIDTH) begin
            k_eff = CNT_W'(WIDTH);
        end else begin
            k_eff = CNT_W'(bus.in_shamt);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = op_e'(bus.in_op);
                    data_d  = bus.in_data;
                    cnt_d   = k_eff;
                    state_d = (k_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = step1(op_q, data_q);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_SLL;
            data_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = busy_q;

`ifdef SERIAL_SHIFTER_FLAGS_EN
    logic carry_q, carry_d;
    logic zero_q;

    // Bit leaving the word on this step; for ROL it is the bit that wraps.
    function automatic logic bit_out(input op_e op, input logic [WIDTH-1:0] d);
        bit_out = (op == OP_SRL || op == OP_SRA) ? d[0] : d[WIDTH-1];
    endfunction

    always_comb begin
        carry_d = carry_q;
        if (state_q == IDLE && bus.in_valid) begin
            carry_d = 1'b0;
        end else if (state_q == SHIFT) begin
            carry_d = bit_out(op_q, data_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= (data_d == '0);
        end
    end

    assign bus.out_carry = carry_q;
    assign bus.out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter: arithmetic reference model, per-cycle compare,
// literal directed cases, randomized operations with backpressure and a mid-shift reset.
module tb_serial_shifter;
    localparam int unsigned W = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_shifter_if #(.WIDTH(W), .SHAMT_W(5)) bif();
    serial_shifter #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: effective amount, result and last bit out, from plain arithmetic.
    function automatic int model_k(input logic [4:0] sh, input logic [1:0] op);
        if (op == 2'b11) return int'(sh) % W;
        return (int'(sh) > W) ? W : int'(sh);
    endfunction

    function automatic logic [W-1:0] model_res(input logic [W-1:0] d, input int k, input logic [1:0] op);
        logic [2*W-1:0] t;
        case (op)
            2'b00: begin t = {{W{1'b0}}, d} << k; return t[W-1:0]; end
            2'b01: return d >> k;
            2'b10: return W'($signed(d) >>> k);
            default: begin t = {d, d} << k; return t[2*W-1:W]; end
        endcase
    endfunction

    function automatic logic model_cy(input logic [W-1:0] d, input int k, input logic [1:0] op);
        if (k == 0) return 1'b0;
        if (op == 2'b01 || op == 2'b10) return d[k-1];
        return d[W-k];
    endfunction

    bit             m_active;
    int             m_edge;
    int             m_done_edge;
    int             m_k;
    logic [W-1:0]   m_res;
    logic           m_carry;

    // Transaction-level model: busy from accept until the output handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else begin
            m_edge++;
            if (!m_active) begin
                if (bif.in_valid) begin
                    m_k         = model_k(bif.in_shamt, bif.in_op);
                    m_res       = model_res(bif.in_data, m_k, bif.in_op);
                    m_carry     = model_cy(bif.in_data, m_k, bif.in_op);
                    m_active    = 1'b1;
                    m_done_edge = m_edge + m_k;
                end
            end else if (m_edge > m_done_edge && bif.out_ready) begin
                m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bif.in_ready), 32'(!m_active));
        chk("busy", 32'(bif.busy), 32'(m_active));
        chk("out_valid", 32'(bif.out_valid), 32'(m_active && m_edge >= m_done_edge));
        if (m_active && m_edge >= m_done_edge) begin
            chk("out_data", 32'(bif.out_data), 32'(m_res));
`ifdef SERIAL_SHIFTER_FLAGS_EN
            chk("out_carry", 32'(bif.out_carry), 32'(m_carry));
            chk("out_zero", 32'(bif.out_zero), 32'(m_res == '0));
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] op,
                          input int stall, output logic [W-1:0] res, output int lat,
                          output logic cy, output logic zf);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bif.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bif.in_ready) chk("in_ready_timeout", 32'(bif.in_ready), 32'h1);
        bif.in_valid  = 1'b1;
        bif.in_data   = d;
        bif.in_shamt  = sh;
        bif.in_op     = op;
        bif.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_data  = W'($urandom);
        bif.in_shamt = 5'($urandom);
        bif.in_op    = 2'($urandom);
        lat = 0;
        while (!bif.out_valid && lat < 100) begin
            bif.out_ready = 1'($urandom_range(0, 1));
            bif.in_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        if (!bif.out_valid) chk("out_valid_timeout", 32'(bif.out_valid), 32'h1);
        res = bif.out_data;
`ifdef SERIAL_SHIFTER_FLAGS_EN
        cy = bif.out_carry;
        zf = bif.out_zero;
`else
        cy = 1'b0;
        zf = 1'b0;
`endif
        for (int i = 0; i < stall; i++) begin
            bif.out_ready = 1'b0;
            bif.in_valid  = 1'($urandom_range(0, 1));
            bif.in_data   = W'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 32'(bif.in_ready), 32'h0);
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [W-1:0] d, input logic [4:0] sh,
                            input logic [1:0] op, input int stall, input logic [31:0] exp_res,
                            input logic [31:0] exp_lat, input logic [31:0] exp_cy,
                            input logic [31:0] exp_zf);
        logic [W-1:0] res;
        int           lat;
        logic         cy, zf;
        run_op(d, sh, op, stall, res, lat, cy, zf);
        chk({nm, "_data"}, 32'(res), exp_res);
        chk({nm, "_lat"}, 32'(lat), exp_lat);
`ifdef SERIAL_SHIFTER_FLAGS_EN
        chk({nm, "_carry"}, 32'(cy), exp_cy);
        chk({nm, "_zero"}, 32'(zf), exp_zf);
`else
        if (cy !== 1'b0 || zf !== 1'b0 || exp_cy > 32'h1 || exp_zf > 32'h1) begin
            chk({nm, "_flagargs"}, 32'(cy), 32'h0);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] res, rd;
        logic [4:0]   rs;
        logic [1:0]   ro;
        int           lat, rst_cnt;
        logic         cy, zf;

        rst_n         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.in_shamt  = '0;
        bif.in_op     = '0;
        bif.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bif.in_ready), 32'h1);
        chk("rst_out_valid", 32'(bif.out_valid), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_out_data", 32'(bif.out_data), 32'h0);
        #20 rst_n = 1'b1;

        directed("sll1",   20'hAAAAA, 5'd1,  2'b00, 0,  32'h55554, 32'd1,  32'h1, 32'h0);
        directed("sra4",   20'h80000, 5'd4,  2'b10, 10, 32'hF8000, 32'd4,  32'h0, 32'h0);
        chk("bp_idle_ready", 32'(bif.in_ready), 32'h1);
        directed("rol1",   20'h80001, 5'd1,  2'b11, 0,  32'h00003, 32'd1,  32'h1, 32'h0);
        directed("rol25",  20'h00001, 5'd25, 2'b11, 2,  32'h00020, 32'd5,  32'h0, 32'h0);
        directed("sllsat", 20'hFFFFF, 5'd31, 2'b00, 1,  32'h00000, 32'd20, 32'h1, 32'h1);
        directed("srl0",   20'h12345, 5'd0,  2'b01, 0,  32'h12345, 32'd0,  32'h0, 32'h0);
        directed("srasat", 20'h8F000, 5'd20, 2'b10, 0,  32'hFFFFF, 32'd20, 32'h1, 32'h0);

        // Abort an SLL by 15 just after its seventh shift edge.
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = 20'h0F0F1;
        bif.in_shamt = 5'd15;
        bif.in_op    = 2'b00;
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", 32'(bif.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bif.in_ready), 32'h1);
        chk("mid_rst_out_valid", 32'(bif.out_valid), 32'h0);
        chk("mid_rst_busy", 32'(bif.busy), 32'h0);
        chk("mid_rst_out_data", 32'(bif.out_data), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        directed("fresh", 20'h0F0F1, 5'd4, 2'b11, 0, 32'hF0F10, 32'd4, 32'h0, 32'h0);

        rst_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            rd = W'($urandom);
            rs = 5'($urandom);
            ro = 2'($urandom);
            if (n % 50 == 7) rd = '0;
            run_op(rd, rs, ro, int'($urandom_range(0, 3)), res, lat, cy, zf);
            chk("rand_lat", 32'(lat), 32'(model_k(rs, ro)));
            chk("rand_data", 32'(res), 32'(model_res(rd, model_k(rs, ro), ro)));
            rst_cnt++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
